// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD CGRAM loader.
package lcd_pkg;

    // Glyph/row sequencing states of the loader.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_ROW    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Phases of one nibble transfer on the LCD bus.
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_PULSE = 2'd1,
        PH_HOLD  = 2'd2,
        PH_GAP   = 2'd3
    } phase_t;

    // Set-CGRAM-address command; the glyph index occupies bits 5:3.
    localparam logic [7:0] CGRAM_CMD = 8'h40;

    function automatic logic [7:0] cgram_cmd(input logic [2:0] glyph);
        return CGRAM_CMD | {2'b00, glyph, 3'b000};
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Serialises one byte as two 4-bit nibbles with SETUP/PULSE/HOLD timing and
// a trailing GAP. Handshake: a byte is taken on a clock edge where
// byte_valid && byte_ready; byte_ready is high while idle and in the final
// cycle of a byte (where byte_done pulses), so bytes can run back to back.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 1,
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [7:0] byte_in,
    input  logic       byte_rs,
    output logic       byte_done,
    output logic       rs,
    output logic       e,
    output logic [3:0] data
);

    localparam int MAX_T = max4(T_SETUP, T_PULSE, T_HOLD, T_GAP);
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((T_GAP > 0) ? T_GAP - 1 : 0);

    logic          active_q;
    logic          hi_q;
    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    lo_nib_q;
    logic          launch;

    // Last cycle of a byte: end of GAP, or end of the low nibble HOLD when there is no gap.
    assign byte_done  = active_q &&
                        ((phase_q == PH_GAP && cnt_q == GAP_LAST) ||
                         ((T_GAP == 0) && phase_q == PH_HOLD && !hi_q && cnt_q == HOLD_LAST));
    assign byte_ready = !active_q || byte_done;
    assign launch     = byte_valid && byte_ready;

    // Nibble phase sequencer; rs/data only change when a nibble's SETUP starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            phase_q  <= PH_SETUP;
            cnt_q    <= '0;
            lo_nib_q <= 4'h0;
            rs       <= 1'b0;
            e        <= 1'b0;
            data     <= 4'h0;
        end else if (launch) begin
            active_q <= 1'b1;
            hi_q     <= 1'b1;
            phase_q  <= PH_SETUP;
            cnt_q    <= '0;
            lo_nib_q <= byte_in[3:0];
            rs       <= byte_rs;
            e        <= 1'b0;
            data     <= byte_in[7:4];
        end else if (byte_done) begin
            active_q <= 1'b0;
            phase_q  <= PH_SETUP;
            cnt_q    <= '0;
        end else if (active_q) begin
            case (phase_q)
                PH_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        phase_q <= PH_PULSE;
                        cnt_q   <= '0;
                        e       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PH_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        phase_q <= PH_HOLD;
                        cnt_q   <= '0;
                        e       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
                        if (hi_q) begin
                            hi_q    <= 1'b0;
                            data    <= lo_nib_q;
                            phase_q <= PH_SETUP;
                        end else begin
                            phase_q <= PH_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_cgram_loader.sv
// Loads glyph patterns into HD44780-style CGRAM over a 4-bit bus: per glyph a
// set-CGRAM-address command followed by eight row bytes from an external ROM.
// The ROM address leads the byte on the bus by one byte so the next row
// pattern is already valid in the cycle that row is launched.
module lcd_cgram_loader
    import lcd_pkg::*;
#(
    parameter int NUM_GLYPHS = 7,
    parameter int T_SETUP    = 1,
    parameter int T_PULSE    = 2,
    parameter int T_HOLD     = 1,
    parameter int T_GAP      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_all,
    input  logic       start_one,
    input  logic [2:0] glyph_sel,
    output logic [2:0] rom_glyph,
    output logic [2:0] rom_row,
    input  logic [4:0] rom_data,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic [3:0] data,
    output logic       busy,
    output logic       done,
    output logic       init_end,
    output logic [1:0] state_dbg
);

    localparam logic [3:0] GLYPH_COUNT = 4'(NUM_GLYPHS);
    localparam logic [2:0] LAST_GLYPH  = 3'(NUM_GLYPHS - 1);

    state_t     state_q;
    logic [2:0] glyph_q;
    logic [2:0] last_q;
    logic [2:0] row_q;
    logic       full_q;

    logic       wr_valid;
    logic       wr_ready;
    logic       wr_done;
    logic [7:0] wr_byte;
    logic       wr_rs;
    logic       take_all;
    logic       take_one;

    assign rw        = 1'b0;
    assign state_dbg = state_q;
    assign take_all  = start_all && wr_ready;
    assign take_one  = start_one && wr_ready && ({1'b0, glyph_sel} < GLYPH_COUNT);

    // Select the next byte to hand to the writer (start_all wins over start_one).
    always_comb begin
        wr_valid = 1'b0;
        wr_byte  = 8'h00;
        wr_rs    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take_all) begin
                    wr_valid = 1'b1;
                    wr_byte  = cgram_cmd(3'd0);
                end else if (take_one) begin
                    wr_valid = 1'b1;
                    wr_byte  = cgram_cmd(glyph_sel);
                end
            end
            ST_CMD: begin
                if (wr_done) begin
                    wr_valid = 1'b1;
                    wr_byte  = {3'b000, rom_data};
                    wr_rs    = 1'b1;
                end
            end
            ST_ROW: begin
                if (wr_done) begin
                    if (row_q != 3'd7) begin
                        wr_valid = 1'b1;
                        wr_byte  = {3'b000, rom_data};
                        wr_rs    = 1'b1;
                    end else if (glyph_q != last_q) begin
                        wr_valid = 1'b1;
                        wr_byte  = cgram_cmd(glyph_q + 3'd1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Glyph/row sequencing FSM with registered status and ROM address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            glyph_q   <= 3'd0;
            last_q    <= 3'd0;
            row_q     <= 3'd0;
            full_q    <= 1'b0;
            rom_glyph <= 3'd0;
            rom_row   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            init_end  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_all) begin
                        glyph_q   <= 3'd0;
                        last_q    <= LAST_GLYPH;
                        full_q    <= 1'b1;
                        row_q     <= 3'd0;
                        rom_glyph <= 3'd0;
                        rom_row   <= 3'd0;
                        busy      <= 1'b1;
                        state_q   <= ST_CMD;
                    end else if (take_one) begin
                        glyph_q   <= glyph_sel;
                        last_q    <= glyph_sel;
                        full_q    <= 1'b0;
                        row_q     <= 3'd0;
                        rom_glyph <= glyph_sel;
                        rom_row   <= 3'd0;
                        busy      <= 1'b1;
                        state_q   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (wr_done) begin
                        row_q   <= 3'd0;
                        rom_row <= 3'd1;
                        state_q <= ST_ROW;
                    end
                end
                ST_ROW: begin
                    if (wr_done) begin
                        if (row_q != 3'd7) begin
                            row_q <= row_q + 3'd1;
                            if (row_q == 3'd6) begin
                                rom_row <= 3'd0;
                                if (glyph_q != last_q) rom_glyph <= glyph_q + 3'd1;
                            end else begin
                                rom_row <= row_q + 3'd2;
                            end
                        end else if (glyph_q != last_q) begin
                            glyph_q <= glyph_q + 3'd1;
                            row_q   <= 3'd0;
                            state_q <= ST_CMD;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            if (full_q) init_end <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                default: begin
                    glyph_q   <= 3'd0;
                    last_q    <= 3'd0;
                    row_q     <= 3'd0;
                    rom_glyph <= 3'd0;
                    rom_row   <= 3'd0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    lcd_nibble_writer #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) u_writer (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (wr_valid),
        .byte_ready (wr_ready),
        .byte_in    (wr_byte),
        .byte_rs    (wr_rs),
        .byte_done  (wr_done),
        .rs         (rs),
        .e          (e),
        .data       (data)
    );

endmodule
